// File: rtl/rv_pkg.sv
// Shared RV32I definitions: bus defaults, read-owner encoding, arbiter read state
// and the load/store funct3 codes used by both the core decode and the memory arbiter.
package rv_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_ADDRSIZE = 8;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  // bit 1 = read pending, bit 0 = owner, so the state word is {rd_pend, rd_owner}
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RD_IF = 2'b10,
    RD_D  = 2'b11
  } rd_state_e;

  localparam logic [2:0] F3_LW = 3'b010;
  localparam logic [2:0] F3_SW = 3'b010;

  function automatic rd_state_e rd_state_for(input logic owner);
    return (owner == OWN_D) ? RD_D : RD_IF;
  endfunction

endpackage

// File: rtl/rv_mem_arbiter_if.sv
// Fetch, load/store and memory-port signals of the RV32I memory arbiter.
// slave = arbiter view, master = core + memory view.
interface rv_mem_arbiter_if #(
  parameter int WIDTH    = 32,
  parameter int ADDRSIZE = 8
);
  logic                if_req;
  logic [ADDRSIZE-1:0] if_addr;
  logic                if_gnt;
  logic                if_rvalid;
  logic [WIDTH-1:0]    if_rdata;

  logic                d_req;
  logic                d_we;
  logic [ADDRSIZE-1:0] d_addr;
  logic [WIDTH-1:0]    d_wdata;
  logic                d_gnt;
  logic                d_rvalid;
  logic [WIDTH-1:0]    d_rdata;

  logic                mem_en;
  logic                mem_we;
  logic [ADDRSIZE-1:0] mem_addr;
  logic [WIDTH-1:0]    mem_wdata;
  logic [WIDTH-1:0]    mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rv_prio_sel.sv
// Fixed-priority grant selector: data wins unless fetch has waited out its streak.
module rv_prio_sel (
  input  logic if_req,
  input  logic d_req,
  input  logic streak_hit,
  output logic if_gnt,
  output logic d_gnt
);

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (d_req && !(if_req && streak_hit)) begin
      d_gnt = 1'b1;
    end else if (if_req) begin
      if_gnt = 1'b1;
    end
  end

endmodule

// File: rtl/rv_mem_arbiter.sv
// Arbitrates fetch and load/store onto one synchronous memory port and routes
// the one-cycle-late read data back to whichever port issued the read.
module rv_mem_arbiter
  import rv_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDRSIZE   = DEF_ADDRSIZE,
  parameter int MAX_STREAK = 4
) (
  input logic             clk,
  input logic             rst,
  rv_mem_arbiter_if.slave bus
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  rd_state_e           state_p1, state_nxt;
  logic [3:0]          streak_p1, streak_nxt;
  logic                streak_hit;
  logic                if_gnt, d_gnt;
  logic                rd_pend;
  logic                mem_we;
  logic [ADDRSIZE-1:0] mem_addr;
  logic [WIDTH-1:0]    mem_wdata;

  assign streak_hit = (streak_p1 == STREAK_MAX);

  // Requests are masked while in reset so no grant or memory strobe can leak out.
  rv_prio_sel u_sel (
    .if_req     (bus.if_req & ~rst),
    .d_req      (bus.d_req & ~rst),
    .streak_hit (streak_hit),
    .if_gnt     (if_gnt),
    .d_gnt      (d_gnt)
  );

  always_comb begin
    state_nxt  = IDLE;
    streak_nxt = streak_p1;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (d_gnt) begin
      mem_we    = bus.d_we;
      mem_addr  = bus.d_addr;
      mem_wdata = bus.d_wdata;
      if (!bus.d_we) state_nxt = rd_state_for(OWN_D);
    end else if (if_gnt) begin
      mem_addr  = bus.if_addr;
      state_nxt = rd_state_for(OWN_IF);
    end
    if (if_gnt || !bus.if_req) begin
      streak_nxt = 4'd0;
    end else if (d_gnt && !streak_hit) begin
      streak_nxt = streak_p1 + 4'd1;
    end
  end

  // Stage p1: read owner and streak registered at the grant edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1  <= IDLE;
      streak_p1 <= 4'd0;
    end else begin
      state_p1  <= state_nxt;
      streak_p1 <= streak_nxt;
    end
  end

  // A read still in flight when reset asserts is dropped here, not at the next edge.
  assign rd_pend = (state_p1 != IDLE) & ~rst;

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_en    = if_gnt | d_gnt;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.if_rvalid = rd_pend & (state_p1 == RD_IF);
  assign bus.d_rvalid  = rd_pend & (state_p1 == RD_D);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Scoreboard bench for rv_mem_arbiter: grant model per cycle, expected read
// returns queued at grant time and popped when the data comes back.
module tb_rv_mem_arbiter;
  import rv_pkg::*;

  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;

  always #5 clk = ~clk;

  rv_mem_arbiter_if #(.WIDTH(32), .ADDRSIZE(8)) bus ();

  rv_mem_arbiter #(.WIDTH(32), .ADDRSIZE(8), .MAX_STREAK(MAXS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous single-port memory
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(32'h100 + i);
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  typedef struct {
    logic        own;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [256];
  int          m_streak = 0;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic ireq, input logic [7:0] iaddr,
                      input logic dreq, input logic dwe, input logic [7:0] daddr,
                      input logic [31:0] dwdata);
    exp_t e;
    logic eg_d, eg_i;
    @(negedge clk);
    rst         = r;
    bus.if_req  = ireq;
    bus.if_addr = iaddr;
    bus.d_req   = dreq;
    bus.d_we    = dwe;
    bus.d_addr  = daddr;
    bus.d_wdata = dwdata;
    #1;
    if (r) sb.delete();
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("if_rvalid", bus.if_rvalid, e.own == OWN_IF);
      chk("d_rvalid", bus.d_rvalid, e.own == OWN_D);
      chk("if_rdata", bus.if_rdata, (e.own == OWN_IF) ? e.data : 32'h0);
      chk("d_rdata", bus.d_rdata, (e.own == OWN_D) ? e.data : 32'h0);
    end else begin
      chk("if_rvalid_quiet", bus.if_rvalid, 1'b0);
      chk("d_rvalid_quiet", bus.d_rvalid, 1'b0);
    end
    eg_d = !r && dreq && !(ireq && m_streak == MAXS);
    eg_i = !r && ireq && !eg_d;
    chk("d_gnt", bus.d_gnt, eg_d);
    chk("if_gnt", bus.if_gnt, eg_i);
    chk("mem_en", bus.mem_en, eg_d | eg_i);
    chk("mem_we", bus.mem_we, eg_d & dwe);
    chk("mem_wdata", bus.mem_wdata, eg_d ? dwdata : 32'h0);
    if (eg_d || eg_i || r) chk("mem_addr", bus.mem_addr, eg_d ? daddr : (eg_i ? iaddr : 8'h0));
    chk("streak", dut.streak_p1, m_streak);
    if (eg_d && !dwe) sb.push_back('{OWN_D, ref_mem[daddr]});
    if (eg_d && dwe)  ref_mem[daddr] = dwdata;
    if (eg_i)         sb.push_back('{OWN_IF, ref_mem[iaddr]});
    if (r || eg_i || !ireq) m_streak = 0;
    else if (eg_d && m_streak < MAXS) m_streak++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 8'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'(32'h100 + i);
    bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0;

    // reset with and without requests pending
    step(1'b1, 1'b0, 8'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    step(1'b1, 1'b1, 8'h3, 1'b1, 1'b0, 8'h4, 32'h0);
    step(1'b1, 1'b1, 8'h3, 1'b1, 1'b1, 8'h4, 32'h55);
    mem_init = 1'b0;

    // first cycle out of reset with both requesting: data wins
    step(1'b0, 1'b1, 8'h3, 1'b1, 1'b0, 8'h20, 32'h0);
    idle(1);

    // fetch only, back-to-back
    for (int a = 0; a < 3; a++) step(1'b0, 1'b1, 8'(a), 1'b0, 1'b0, 8'h0, 32'h0);
    idle(1);

    // store then load the same word
    step(1'b0, 1'b0, 8'h0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
    step(1'b0, 1'b0, 8'h0, 1'b1, 1'b0, 8'h10, 32'h0);
    idle(1);

    // contention: D,D,D,D,IF repeating
    for (int c = 0; c < 12; c++) step(1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 8'h31, 32'h0);
    idle(1);

    // alternating returns
    for (int c = 0; c < 6; c++) begin
      if (c % 2 == 0) step(1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 8'h0, 32'h0);
      else            step(1'b0, 1'b0, 8'h0, 1'b1, 1'b0, 8'h06, 32'h0);
    end

    // reset arriving the cycle after a granted load
    step(1'b0, 1'b0, 8'h0, 1'b1, 1'b0, 8'h06, 32'h0);
    step(1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 8'h06, 32'h0);
    step(1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 8'h06, 32'h0);
    idle(1);

    // idle
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rv_mem_arbiter.md
# rv_mem_arbiter

Two-port arbiter between the RV32I core's instruction-fetch path and its load/store path and the single-port synchronous program/data memory. Each cycle it grants at most one request, drives the memory port, and routes the one-cycle-late read data back to the requester that issued it. Data accesses take priority; a streak counter stops fetch from starving.

## Interface
Parameters:
- `WIDTH`, 32, data bus width
- `ADDRSIZE`, 8, word address width
- `MAX_STREAK`, 4, consecutive data grants allowed while fetch waits; range 1–15

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `if_req`  in  1  fetch request
- `if_addr`  in  ADDRSIZE  fetch word address
- `if_gnt`  out  1  fetch granted this cycle (combinational)
- `if_rvalid`  out  1  fetch read data valid
- `if_rdata`  out  WIDTH  fetch read data
- `d_req`  in  1  load/store request
- `d_we`  in  1  1 = store (SW), 0 = load (LW)
- `d_addr`  in  ADDRSIZE  data word address
- `d_wdata`  in  WIDTH  store data
- `d_gnt`  out  1  data granted this cycle (combinational)
- `d_rvalid`  out  1  load data valid
- `d_rdata`  out  WIDTH  load data
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDRSIZE  memory address
- `mem_wdata`  out  WIDTH  memory write data
- `mem_rdata`  in  WIDTH  memory read data, valid the cycle after a read with `mem_en=1`, `mem_we=0`

## Operation
- Requester holds `req`, address, `we`, and `wdata` stable until it sees `gnt`. It may drop `req` in the cycle after `gnt` or issue a new request.
- Grant selection:
  - Only `d_req` high: grant data.
  - Only `if_req` high: grant fetch.
  - Both high: grant data unless `streak == MAX_STREAK`, in which case grant fetch.
- Memory port:
  - `mem_en = if_gnt | d_gnt`.
  - `mem_addr`, `mem_we`, and `mem_wdata` are muxed from the granted port.
  - A fetch grant always drives `mem_we=0` and `mem_wdata=0`.
- `streak` counter, 4 bits:
  - Increments on a data grant while `if_req` is high.
  - Clears on any fetch grant, or when `if_req` is low.
  - Saturates at `MAX_STREAK`.
- Read tracking uses register `rd_pend` plus `rd_owner` (IF / D):
  - Set on a granted read; cleared next cycle unless another read is granted.
  - A store sets no pending read and produces no `rvalid`.
- Return path:
  - `if_rvalid = rd_pend & rd_owner==IF`.
  - `d_rvalid = rd_pend & rd_owner==D`.
  - Both `rdata` outputs are driven from `mem_rdata` and are 0 when their `rvalid` is low.
- A granted read and a returning read can share a cycle, giving full throughput of one access per cycle.
- FSM states: IDLE (no read pending), RD_IF, RD_D; the state holds `rd_owner`.
  - Transitions come only from the grant made in the current cycle: granted read → RD_IF or RD_D; no read granted → IDLE.
- Reset:
  - Registers: `streak=0`, state IDLE.
  - Outputs during and after reset: all `gnt`/`rvalid`/`mem_*` = 0.
  - While `rst` is high, no grants are issued regardless of `req`.
  - A read in flight when `rst` asserts is discarded; no `rvalid` follows.

## Timing
- Grant: combinational, in the same cycle as the request.
- Read data: one-cycle latency from grant to `rvalid`.
- Store: takes effect at the grant edge; zero added latency.
- Back-to-back grants to the same or alternating ports: every cycle, no bubbles.
- Worst-case fetch wait under continuous data traffic: `MAX_STREAK` cycles, then granted.
- Simultaneous `req` on the first cycle after reset deasserts: data is granted (`streak=0`).

## Structure
- Shared package `rv_pkg` holds:
  - `WIDTH` and `ADDRSIZE` defaults
  - owner encoding (`OWN_IF=0`, `OWN_D=1`)
  - state typedef (IDLE, RD_IF, RD_D)
  - the `LW`/`SW` funct3 constants, shared with the core decode
- One natural sub-module, `rv_prio_sel`: combinational fixed-priority-with-override selector taking `if_req`, `d_req`, and `streak_hit`, and returning the two grants. All state lives in the top.

## Test plan
- Fetch only: `if_req=1` with addr 0,1,2 on consecutive cycles and memory preloaded `MEM[i]=0x100+i` → `if_gnt` each cycle; `if_rvalid` one cycle later with `if_rdata` 0x100, 0x101, 0x102.
- Store then load: SW `d_addr=0x10`, `wdata=0xDEADBEEF`; next cycle LW 0x10 → `d_gnt` both cycles, no `rvalid` after the SW, `d_rvalid` with 0xDEADBEEF after the LW.
- Contention: `if_req` and `d_req` held high for 12 cycles with `MAX_STREAK=4` → grant pattern D,D,D,D,IF repeating; each `rvalid` routed to the correct port.
- Interleaved returns: alternate IF read 0x05 and D read 0x06 each cycle → `if_rvalid` and `d_rvalid` alternate with no overlap and correct data.
- Reset mid-read: grant D read at cycle N, assert `rst` at cycle N+1 → `d_rvalid=0` at N+1 and beyond; `streak=0`; no grants while `rst` is high.
- Idle: no requests for 5 cycles → `mem_en=0`, all `rvalid=0`, `streak` stays 0.
